mem_stage: RTL and testbench

Memory stage of the pipelined MIPS core, and the producer side of the MEM/WB pipeline latch. It accepts one instruction at a time from EX/MEM and issues the data-cache read or write it requires. It holds the request until `dhit`, then presents a one-cycle `wb_valid` beat carrying every MEM/WB input field. It also generates the upstream stall and the sticky halt.

---
 rtl/cpu_types_pkg.sv | 26 ++
 rtl/mem_req_timer.sv | 34 +++
 rtl/mem_stage.sv | 165 ++++++++++++++++
 tb/tb_mem_stage.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the pipelined MIPS core: data words, register indices,
// writeback-source encoding and the memory-stage FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [1:0] {
    MTR_ALU = 2'd0,
    MTR_MEM = 2'd1,
    MTR_LUI = 2'd2,
    MTR_PC4 = 2'd3
  } memtoreg_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    HALTED = 2'd2
  } mem_state_t;

  // Request-timeout counter width: wide enough for the limit, never below 8 bits.
  function automatic int timerWidth(input int cycles);
    return ($clog2(cycles + 1) > 8) ? $clog2(cycles + 1) : 8;
  endfunction

endpackage

// File: rtl/mem_req_timer.sv
// Counts cycles a data-cache request has been outstanding and flags expiry
// on the cycle the limit is reached without a hit.
module mem_req_timer
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic CLK,
  input  logic nRST,
  input  logic start,
  input  logic active,
  input  logic hit,
  output logic expire
);

  localparam int CW = timerWidth(TIMEOUT_CYCLES);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else if (active && !hit) begin
      count <= count + CW'(1);
    end
  end

  // A hit on the expiry cycle takes precedence over the timeout.
  assign expire = active && !hit && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage feeding the MEM/WB latch. Optional request timeout is
// enabled by defining MEM_STAGE_TIMEOUT_EN.
module mem_stage
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        regWr,
  input  logic        halt,
  input  logic [4:0]  wsel,
  input  logic [1:0]  memToReg,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [31:0] luiValue,
  input  logic [31:0] pc4,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        wb_valid,
  output logic        regWr_out,
  output logic        halt_out,
  output logic [4:0]  wsel_out,
  output logic [1:0]  memToReg_out,
  output logic [31:0] dmemload_out,
  output logic [31:0] portO_out,
  output logic [31:0] luiValue_out,
  output logic [31:0] pc4_out,
  output logic        mem_err
);

  if (TIMEOUT_CYCLES < 1) begin : g_badTimeout
    $error("mem_stage: TIMEOUT_CYCLES must be at least 1");
  end

  mem_state_t state;

  logic      reqWrite;
  logic      reqRegWr;
  logic      reqHalt;
  regbits_t  reqWsel;
  memtoreg_t reqMtr;
  word_t     reqAddr;
  word_t     reqStore;
  word_t     reqLui;
  word_t     reqPc4;

  logic inReq;
  logic acceptMem;
  logic expire;

  assign inReq     = (state == REQ);
  assign ex_ready  = (state == IDLE);
  assign acceptMem = ex_ready && ex_valid && (memRead || memWrite);

  assign dmemREN   = inReq && !reqWrite;
  assign dmemWEN   = inReq && reqWrite;
  assign dmemaddr  = reqAddr;
  assign dmemstore = reqStore;

`ifdef MEM_STAGE_TIMEOUT_EN
  mem_req_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .CLK   (CLK),
    .nRST  (nRST),
    .start (acceptMem),
    .active(inReq),
    .hit   (dhit),
    .expire(expire)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mem_err <= 1'b0;
    end else if (expire) begin
      mem_err <= 1'b1;
    end
  end
`else
  assign expire  = 1'b0;
  assign mem_err = 1'b0;
`endif

  // NOTE: request latches are reset too, since they drive dmemaddr/dmemstore directly and every output must read 0 in reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= IDLE;
      reqWrite     <= 1'b0;
      reqRegWr     <= 1'b0;
      reqHalt      <= 1'b0;
      reqWsel      <= '0;
      reqMtr       <= MTR_ALU;
      reqAddr      <= '0;
      reqStore     <= '0;
      reqLui       <= '0;
      reqPc4       <= '0;
      wb_valid     <= 1'b0;
      regWr_out    <= 1'b0;
      halt_out     <= 1'b0;
      wsel_out     <= '0;
      memToReg_out <= '0;
      dmemload_out <= '0;
      portO_out    <= '0;
      luiValue_out <= '0;
      pc4_out      <= '0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid && (memRead || memWrite)) begin
            // A simultaneous read and write request is treated as a write.
            reqWrite <= memWrite;
            reqRegWr <= regWr;
            reqHalt  <= halt;
            reqWsel  <= wsel;
            reqMtr   <= memtoreg_t'(memToReg);
            reqAddr  <= alu_result;
            reqStore <= store_data;
            reqLui   <= luiValue;
            reqPc4   <= pc4;
            state    <= REQ;
          end else if (ex_valid) begin
            wb_valid     <= 1'b1;
            regWr_out    <= regWr;
            halt_out     <= halt;
            wsel_out     <= wsel;
            memToReg_out <= memToReg;
            dmemload_out <= '0;
            portO_out    <= alu_result;
            luiValue_out <= luiValue;
            pc4_out      <= pc4;
            state        <= halt ? HALTED : IDLE;
          end
        end
        REQ: begin
          if (dhit || expire) begin
            // An abandoned request still retires, but cannot write or halt.
            wb_valid     <= 1'b1;
            regWr_out    <= reqRegWr && dhit;
            halt_out     <= reqHalt && dhit;
            wsel_out     <= reqWsel;
            memToReg_out <= reqMtr;
            dmemload_out <= (dhit && !reqWrite) ? dmemload : '0;
            portO_out    <= reqAddr;
            luiValue_out <= reqLui;
            pc4_out      <= reqPc4;
            state        <= (dhit && reqHalt) ? HALTED : IDLE;
          end
        end
        HALTED: state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized ops
// compared against a transaction-level model of the MEM/WB record.
module tb_mem_stage;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ex_valid = 1'b0, memRead = 1'b0, memWrite = 1'b0, regWr = 1'b0, halt = 1'b0;
  logic [4:0]  wsel = '0;
  logic [1:0]  memToReg = '0;
  logic [31:0] alu_result = '0, store_data = '0, luiValue = '0, pc4 = '0;
  logic        dhit = 1'b0;
  logic [31:0] dmemload = '0;
  logic        ex_ready, dmemREN, dmemWEN, wb_valid, regWr_out, halt_out, mem_err;
  logic [31:0] dmemaddr, dmemstore, dmemload_out, portO_out, luiValue_out, pc4_out;
  logic [4:0]  wsel_out;
  logic [1:0]  memToReg_out;

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .nRST(nRST), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .memRead(memRead), .memWrite(memWrite), .regWr(regWr), .halt(halt),
    .wsel(wsel), .memToReg(memToReg), .alu_result(alu_result),
    .store_data(store_data), .luiValue(luiValue), .pc4(pc4),
    .dhit(dhit), .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .wb_valid(wb_valid),
    .regWr_out(regWr_out), .halt_out(halt_out), .wsel_out(wsel_out),
    .memToReg_out(memToReg_out), .dmemload_out(dmemload_out),
    .portO_out(portO_out), .luiValue_out(luiValue_out), .pc4_out(pc4_out),
    .mem_err(mem_err)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Expected MEM/WB record, updated whenever a beat is due.
  logic        expRegWr = 1'b0, expHalt = 1'b0, expMemErr = 1'b0;
  logic [4:0]  expWsel = '0;
  logic [1:0]  expMtr = '0;
  logic [31:0] expLoad = '0, expPortO = '0, expLui = '0, expPc4 = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkRec(input string tag);
    check({tag, ".regWr"},    32'(regWr_out),    32'(expRegWr));
    check({tag, ".halt"},     32'(halt_out),     32'(expHalt));
    check({tag, ".wsel"},     32'(wsel_out),     32'(expWsel));
    check({tag, ".memToReg"}, 32'(memToReg_out), 32'(expMtr));
    check({tag, ".load"},     dmemload_out,      expLoad);
    check({tag, ".portO"},    portO_out,         expPortO);
    check({tag, ".lui"},      luiValue_out,      expLui);
    check({tag, ".pc4"},      pc4_out,           expPc4);
    check({tag, ".mem_err"},  32'(mem_err),      32'(expMemErr));
  endtask

  task automatic randFields();
    alu_result = $urandom;
    store_data = $urandom;
    luiValue   = $urandom;
    pc4        = $urandom;
    wsel       = 5'($urandom);
    memToReg   = 2'($urandom);
    regWr      = 1'($urandom);
  endtask

  // Issues the op currently on the EX/MEM inputs; a memory op gets dhit on
  // its lat-th wait cycle with read data rdata.
  task automatic runOp(input string tag, input int lat, input logic [31:0] rdata);
    bit          isMem = memRead || memWrite;
    bit          isWr = memWrite;
    bit          h = halt;
    logic [31:0] addr = alu_result;
    logic [31:0] sd = store_data;
    expRegWr = regWr;
    expHalt  = halt;
    expWsel  = wsel;
    expMtr   = memToReg;
    expPortO = alu_result;
    expLui   = luiValue;
    expPc4   = pc4;
    expLoad  = (isMem && !isWr) ? rdata : 32'h0;
    check({tag, ".ready_in"}, 32'(ex_ready), 32'd1);
    ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0; memRead = 1'b0; memWrite = 1'b0; halt = 1'b0;
    randFields();
    if (isMem) begin
      for (int i = 0; i < lat; i++) begin
        check({tag, ".ren"},   32'(dmemREN),  32'(!isWr));
        check({tag, ".wen"},   32'(dmemWEN),  32'(isWr));
        check({tag, ".addr"},  dmemaddr,      addr);
        check({tag, ".store"}, dmemstore,     sd);
        check({tag, ".busy"},  32'(ex_ready), 32'd0);
        check({tag, ".nowb"},  32'(wb_valid), 32'd0);
        dhit = (i == lat - 1);
        dmemload = dhit ? rdata : $urandom;
        tick();
        dhit = 1'b0;
      end
    end
    check({tag, ".wb"},      32'(wb_valid),         32'd1);
    check({tag, ".strobes"}, 32'({dmemREN, dmemWEN}), 32'd0);
    check({tag, ".ready"},   32'(ex_ready),         32'(!h));
    checkRec(tag);
    tick();
    check({tag, ".wb_end"}, 32'(wb_valid), 32'd0);
    checkRec({tag, ".hold"});
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, ".strobes"}, 32'({dmemREN, dmemWEN, wb_valid, regWr_out, halt_out, mem_err}), 32'd0);
    check({tag, ".addr"},   dmemaddr | dmemstore, 32'd0);
    check({tag, ".fields"}, dmemload_out | portO_out | luiValue_out | pc4_out, 32'd0);
    check({tag, ".sel"},    32'({wsel_out, memToReg_out}), 32'd0);
    check({tag, ".ready"},  32'(ex_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    // Reset state
    #12;
    checkAllZero("reset");
    @(negedge CLK);
    nRST = 1'b1;
    tick();
    checkAllZero("post_reset");

    // ADD: non-memory op
    randFields();
    alu_result = 32'h0000_0010; wsel = 5'd5; regWr = 1'b1; memToReg = 2'd0;
    runOp("add", 0, 32'h0);
    check("add.portO_const", portO_out, 32'h10);
    check("add.wsel_const",  32'(wsel_out), 32'd5);

    // Load with three wait cycles
    randFields();
    alu_result = 32'h100; memRead = 1'b1;
    runOp("load", 3, 32'hDEAD_BEEF);
    check("load.data_const", dmemload_out, 32'hDEAD_BEEF);

    // Both strobes: write wins
    randFields();
    store_data = 32'h1234; memRead = 1'b1; memWrite = 1'b1;
    runOp("store_both", 2, 32'hFFFF_FFFF);
    check("store_both.load0", dmemload_out, 32'h0);

    // Back-to-back non-memory ops at one per cycle
    ex_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      randFields();
      expPortO = alu_result;
      tick();
      check("b2b.wb", 32'(wb_valid), 32'd1);
      check("b2b.portO", portO_out, expPortO);
    end
    ex_valid = 1'b0;
    tick();

    // dhit while idle is ignored
    dhit = 1'b1; dmemload = 32'hA5A5_A5A5;
    tick();
    dhit = 1'b0;
    check("idle_dhit.wb", 32'(wb_valid), 32'd0);
    check("idle_dhit.ready", 32'(ex_ready), 32'd1);

    // Randomized ops, dhit latency up to the timeout boundary
    for (int n = 0; n < 30; n++) begin
      int kind = int'($urandom_range(0, 3));
      randFields();
      memRead  = (kind == 1) || (kind == 3);
      memWrite = (kind >= 2);
      runOp("rand", int'($urandom_range(1, TO)), $urandom);
    end

`ifdef MEM_STAGE_TIMEOUT_EN
    // Timeout: no dhit for TO cycles
    randFields();
    regWr = 1'b1; memRead = 1'b1;
    ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0; memRead = 1'b0;
    for (int i = 0; i < TO; i++) begin
      check("timeout.ren", 32'(dmemREN), 32'd1);
      check("timeout.nowb", 32'(wb_valid), 32'd0);
      tick();
    end
    check("timeout.wb", 32'(wb_valid), 32'd1);
    check("timeout.regWr", 32'(regWr_out), 32'd0);
    check("timeout.halt", 32'(halt_out), 32'd0);
    check("timeout.mem_err", 32'(mem_err), 32'd1);
    check("timeout.ready", 32'(ex_ready), 32'd1);
    expMemErr = 1'b1;
    tick();
    randFields();
    runOp("after_timeout", 0, 32'h0);
`else
    // Without the timeout a request waits indefinitely
    randFields();
    memRead = 1'b1;
    ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0; memRead = 1'b0;
    repeat (20) tick();
    check("no_timeout.ren", 32'(dmemREN), 32'd1);
    check("no_timeout.nowb", 32'(wb_valid), 32'd0);
    check("no_timeout.mem_err", 32'(mem_err), 32'd0);
    dhit = 1'b1;
    tick();
    dhit = 1'b0;
    check("no_timeout.wb", 32'(wb_valid), 32'd1);
    tick();
`endif

    // Reset in the middle of a request
    randFields();
    memRead = 1'b1;
    ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0; memRead = 1'b0;
    tick();
    check("rst_mid.ren_before", 32'(dmemREN), 32'd1);
    #2 nRST = 1'b0;
    #1;
    check("rst_mid.ren_async", 32'(dmemREN), 32'd0);
    expMemErr = 1'b0;
    checkAllZero("rst_mid");
    @(negedge CLK);
    nRST = 1'b1;
    dhit = 1'b1;
    tick();
    dhit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rst_mid.nowb", 32'(wb_valid), 32'd0);
      check("rst_mid.ready", 32'(ex_ready), 32'd1);
      tick();
    end

    // Halt carried with a load
    randFields();
    halt = 1'b1; memRead = 1'b1;
    runOp("halt_load", 2, 32'h0BAD_F00D);
    ex_valid = 1'b1;
    randFields();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("halted.ready", 32'(ex_ready), 32'd0);
      check("halted.wb", 32'(wb_valid), 32'd0);
      check("halted.halt_out", 32'(halt_out), 32'd1);
      check("halted.ren", 32'(dmemREN), 32'd0);
    end
    ex_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
